// File: rtl/merge_pkg.sv
// Shared types for the two-way sorted merge.
package merge_pkg;

  localparam int MERGE_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    BOTH   = 2'd0,
    ONLY_A = 2'd1,
    ONLY_B = 2'd2
  } merge_state_t;

endpackage

// File: rtl/merge_select.sv
// Head selection for the merge: one compare per cycle, picks which input
// (if any) is popped this cycle given the state and output availability.
module merge_select
  import merge_pkg::*;
#(
  parameter int WIDTH = MERGE_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  input  merge_state_t     state,
  input  logic             load,
  output logic             sel_a,
  output logic             sel_b,
  output logic             le
);

  // Ties resolve towards A so equal keys keep their A-before-B order.
  assign le = (a_data <= b_data);

  // Pop at most one head; in BOTH a lone valid head never pops.
  always_comb begin
    sel_a = 1'b0;
    sel_b = 1'b0;
    unique case (state)
      BOTH: begin
        if (a_valid && b_valid && load) begin
          sel_a = le;
          sel_b = !le;
        end
      end
      ONLY_A:  sel_a = a_valid && load;
      ONLY_B:  sel_b = b_valid && load;
      default: ;
    endcase
  end

endmodule

// File: rtl/sorted_merge8.sv
// Streaming two-way merge of ascending runs into one ascending run.
//
//   state  | meaning
//   BOTH   | neither run finished; compare heads
//   ONLY_A | B run finished; pass A through until its last
//   ONLY_B | A run finished; pass B through until its last
module sorted_merge8
  import merge_pkg::*;
#(
  parameter int WIDTH = MERGE_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             order_err
);

  merge_state_t     state;
  merge_state_t     state_nxt;
  logic             load;
  logic             sel_a;
  logic             sel_b;
  logic             le;
  logic             last_nxt;
  logic [WIDTH-1:0] held_a;
  logic [WIDTH-1:0] held_b;
  logic             in_run_a;
  logic             in_run_b;
  logic             bad_a;
  logic             bad_b;

  assign load = !out_valid || out_ready;

  merge_select #(.WIDTH(WIDTH)) u_select (
    .a_data  (a_data),
    .a_valid (a_valid),
    .b_data  (b_data),
    .b_valid (b_valid),
    .state   (state),
    .load    (load),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .le      (le)
  );

  // Readies are held low through reset so nothing is consumed then dropped.
  assign a_ready = sel_a && !rst;
  assign b_ready = sel_b && !rst;

  // A descending step inside a run is an upstream ordering fault.
  assign bad_a = in_run_a && (a_data < held_a);
  assign bad_b = in_run_b && (b_data < held_b);

  // Next state and end-of-merged-run flag from the popped element.
  always_comb begin
    state_nxt = state;
    last_nxt  = 1'b0;
    unique case (state)
      BOTH: begin
        if (sel_a && a_last) state_nxt = ONLY_B;
        else if (sel_b && b_last) state_nxt = ONLY_A;
      end
      ONLY_A: begin
        if (sel_a && a_last) begin
          state_nxt = BOTH;
          last_nxt  = 1'b1;
        end
      end
      ONLY_B: begin
        if (sel_b && b_last) begin
          state_nxt = BOTH;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = BOTH;
    endcase
  end

  // State register and output register; a pop refills even while draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOTH;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;
      if (sel_a || sel_b) begin
        out_valid <= 1'b1;
        out_data  <= sel_a ? a_data : b_data;
        out_last  <= last_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Per-stream order checkers; order_err is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_a    <= '0;
      held_b    <= '0;
      in_run_a  <= 1'b0;
      in_run_b  <= 1'b0;
      order_err <= 1'b0;
    end else begin
      if (a_ready) begin
        held_a   <= a_data;
        in_run_a <= !a_last;
        if (bad_a) order_err <= 1'b1;
      end
      if (b_ready) begin
        held_b   <= b_data;
        in_run_b <= !b_last;
        if (bad_b) order_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sorted_merge8.sv
// Self-checking bench for sorted_merge8 (instantiated at WIDTH = 9).
module tb_sorted_merge8;
  import merge_pkg::*;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a_data = '0;
  logic         a_last = 1'b0;
  logic         a_valid = 1'b0;
  logic         a_ready;
  logic [W-1:0] b_data = '0;
  logic         b_last = 1'b0;
  logic         b_valid = 1'b0;
  logic         b_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         order_err;

  sorted_merge8 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_data    (a_data),
    .a_last    (a_last),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_last    (b_last),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .order_err (order_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           an;
    logic [W-1:0] a[4];
    int           bn;
    logic [W-1:0] b[4];
    int           en;
    logic [W-1:0] e[8];
    bit           es[8];
    bit           bp;
  } vec_t;

  vec_t vecs[5];

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] qa_data[$];
  bit           qa_last[$];
  logic [W-1:0] qb_data[$];
  bit           qb_last[$];
  logic [W-1:0] exp_data[$];
  bit           exp_last[$];
  bit           exp_src[$];
  bit           acc_src[$];

  int           ai, bi, oi;
  bit           a_pres, b_pres;
  bit           exp_err;
  bit           m_inrun_a, m_inrun_b;
  logic [W-1:0] m_held_a, m_held_b;
  bit           seen_only_b;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic clear_queues();
    qa_data.delete(); qa_last.delete();
    qb_data.delete(); qb_last.delete();
    exp_data.delete(); exp_last.delete(); exp_src.delete();
    acc_src.delete();
    ai = 0; bi = 0; oi = 0;
    a_pres = 0; b_pres = 0;
    seen_only_b = 0;
  endtask

  // Reference: plain stable two-way merge of one pair of runs.
  task automatic model_pair(input int a[$], input int b[$]);
    int i = 0;
    int j = 0;
    int n = a.size() + b.size();
    for (int k = 0; k < n; k++) begin
      bit take_a;
      if (i < a.size() && j < b.size()) take_a = (a[i] <= b[j]);
      else take_a = (i < a.size());
      if (take_a) begin exp_data.push_back(W'(a[i])); exp_src.push_back(1'b0); i++; end
      else        begin exp_data.push_back(W'(b[j])); exp_src.push_back(1'b1); j++; end
      exp_last.push_back(k == n - 1);
    end
    foreach (a[k]) begin qa_data.push_back(W'(a[k])); qa_last.push_back(k == a.size() - 1); end
    foreach (b[k]) begin qb_data.push_back(W'(b[k])); qb_last.push_back(k == b.size() - 1); end
  endtask

  // Drives both sources, checks each output beat, stall stability and order_err.
  task automatic run_stream(input string tag, input bit bp, input bit gaps,
                            input int stop_after, input int budget, output int cycles);
    bit           prev_stall = 0;
    logic [W-1:0] prev_data = '0;
    bit           prev_last = 0;
    int           target = (stop_after > 0) ? stop_after : exp_data.size();
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!a_pres && ai < qa_data.size() && (!gaps || $urandom_range(0, 3) != 0)) a_pres = 1;
      if (!b_pres && bi < qb_data.size() && (!gaps || $urandom_range(0, 3) != 0)) b_pres = 1;
      a_valid = a_pres;
      a_data  = a_pres ? qa_data[ai] : '0;
      a_last  = a_pres ? qa_last[ai] : 1'b0;
      b_valid = b_pres;
      b_data  = b_pres ? qb_data[bi] : '0;
      b_last  = b_pres ? qb_last[bi] : 1'b0;
      #1;
      if (dut.state == ONLY_B) seen_only_b = 1;
      if (prev_stall) begin
        chk({tag, " stall out_valid"}, 32'(out_valid), 1);
        chk({tag, " stall out_data"}, 32'(out_data), 32'(prev_data));
        chk({tag, " stall out_last"}, 32'(out_last), 32'(prev_last));
      end
      if (out_valid && !out_ready)
        chk({tag, " readies under backpressure"}, 32'({a_ready, b_ready}), 0);
      chk({tag, " order_err"}, 32'(order_err), 32'(exp_err));
      if (a_ready && b_ready) chk({tag, " both readies"}, 1, 0);
      if (out_valid && out_ready) begin
        if (oi < exp_data.size() && oi < acc_src.size()) begin
          chk($sformatf("%s out_data[%0d]", tag, oi), 32'(out_data), 32'(exp_data[oi]));
          chk($sformatf("%s out_last[%0d]", tag, oi), 32'(out_last), 32'(exp_last[oi]));
          chk($sformatf("%s source[%0d]", tag, oi), 32'(acc_src[oi]), 32'(exp_src[oi]));
        end else begin
          chk($sformatf("%s extra output beat %0d", tag, oi), 32'(out_data), -1);
        end
        oi++;
      end
      if (a_ready) begin
        if (!a_pres) chk({tag, " a_ready without a_valid"}, 1, 0);
        else begin
          acc_src.push_back(1'b0);
          if (m_inrun_a && a_data < m_held_a) exp_err = 1;
          m_held_a = a_data; m_inrun_a = !a_last;
          ai++; a_pres = 0;
        end
      end
      if (b_ready) begin
        if (!b_pres) chk({tag, " b_ready without b_valid"}, 1, 0);
        else begin
          acc_src.push_back(1'b1);
          if (m_inrun_b && b_data < m_held_b) exp_err = 1;
          m_held_b = b_data; m_inrun_b = !b_last;
          bi++; b_pres = 0;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      @(posedge clk);
      cycles++;
      if (oi >= target) break;
    end
    if (oi < target) chk({tag, " timeout outputs seen"}, oi, target);
  endtask

  task automatic model_reset();
    exp_err = 0; m_inrun_a = 0; m_inrun_b = 0; m_held_a = '0; m_held_b = '0;
  endtask

  initial begin
    int cyc;
    int qa[$];
    int qb[$];

    vecs[0] = '{3, '{1,4,9,0}, 3, '{2,3,10,0}, 6, '{1,2,3,4,9,10,0,0}, '{0,1,1,0,0,1,0,0}, 0};
    vecs[1] = '{2, '{5,5,0,0}, 1, '{5,0,0,0},  3, '{5,5,5,0,0,0,0,0},   '{0,0,1,0,0,0,0,0}, 0};
    vecs[2] = '{1, '{7,0,0,0}, 4, '{1,2,8,20}, 5, '{1,2,7,8,20,0,0,0},  '{1,1,0,1,1,0,0,0}, 0};
    vecs[3] = '{3, '{1,4,9,0}, 3, '{2,3,10,0}, 6, '{1,2,3,4,9,10,0,0}, '{0,1,1,0,0,1,0,0}, 1};
    vecs[4] = '{2, '{3,2,0,0}, 1, '{4,0,0,0},  3, '{3,2,4,0,0,0,0,0},   '{0,0,1,0,0,0,0,0}, 0};

    model_reset();
    clear_queues();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_last", 32'(out_last), 0);
    chk("reset out_data", 32'(out_data), 0);
    chk("reset order_err", 32'(order_err), 0);
    chk("reset state", 32'(dut.state), 32'(BOTH));
    rst = 0;

    for (int v = 0; v < 5; v++) begin
      clear_queues();
      for (int k = 0; k < vecs[v].an; k++) begin
        qa_data.push_back(vecs[v].a[k]); qa_last.push_back(k == vecs[v].an - 1);
      end
      for (int k = 0; k < vecs[v].bn; k++) begin
        qb_data.push_back(vecs[v].b[k]); qb_last.push_back(k == vecs[v].bn - 1);
      end
      for (int k = 0; k < vecs[v].en; k++) begin
        exp_data.push_back(vecs[v].e[k]);
        exp_src.push_back(vecs[v].es[k]);
        exp_last.push_back(k == vecs[v].en - 1);
      end
      run_stream($sformatf("vec%0d", v), vecs[v].bp, 1'b0, 0, 200, cyc);
      if (v == 0) chk("vec0 cycles for 6 beats", cyc, 7);
      if (v == 2) chk("vec2 passed through ONLY_B", 32'(seen_only_b), 1);
      if (v == 4) chk("vec4 order_err sticky", 32'(order_err), 1);
    end

    // Reset in the middle of a merge, then fresh runs.
    clear_queues();
    qa = '{1, 4, 9}; qb = '{2, 3, 10};
    model_pair(qa, qb);
    run_stream("rst_mid", 1'b0, 1'b0, 2, 100, cyc);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_mid readies in reset", 32'({a_ready, b_ready}), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    a_valid = 0; b_valid = 0;
    #1;
    chk("rst_mid out_valid", 32'(out_valid), 0);
    chk("rst_mid state", 32'(dut.state), 32'(BOTH));
    chk("rst_mid order_err cleared", 32'(order_err), 0);
    model_reset();
    clear_queues();
    qa = '{0}; qb = '{255};
    model_pair(qa, qb);
    run_stream("rst_fresh", 1'b0, 1'b0, 0, 100, cyc);

    // Randomized back-to-back run pairs against the reference merge.
    clear_queues();
    for (int p = 0; p < 25; p++) begin
      int v;
      qa.delete(); qb.delete();
      v = $urandom_range(0, 60);
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
        v = (v + int'($urandom_range(0, 40)) > 511) ? 511 : v + int'($urandom_range(0, 40));
        qa.push_back(v);
      end
      v = $urandom_range(0, 60);
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
        v = (v + int'($urandom_range(0, 40)) > 511) ? 511 : v + int'($urandom_range(0, 40));
        qb.push_back(v);
      end
      model_pair(qa, qb);
    end
    run_stream("rand", 1'b1, 1'b1, 0, 8000, cyc);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sorted_merge8.md
# sorted_merge8

Streaming two-way merge: accepts two independently handshaked streams, each already in ascending order and terminated by a `last` flag, and emits one ascending stream containing every element of both. It sits downstream of the pairwise sorter stages, combining sorted runs into longer runs. It is the sequential consumer side of the compare/swap primitive: one comparison per cycle, one element out per cycle.

## Interface
- `WIDTH`, default 8, element width in bits (unsigned).
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset; synchronous and active-high.
- `a_data`  in  WIDTH  head element of stream A.
- `a_last`  in  1  marks the final element of the current A run.
- `a_valid`  in  1  A head present.
- `a_ready`  out  1  A head consumed this cycle.
- `b_data`, `b_last`, `b_valid`  in  WIDTH/1/1  as for A.
- `b_ready`  out  1  as for A.
- `out_data`  out  WIDTH  merged element (registered).
- `out_last`  out  1  final element of the merged run.
- `out_valid`  out  1  output register full.
- `out_ready`  in  1  downstream accepts.
- `order_err`  out  1  sticky: an input run was not ascending.

## Operation
- Handshake: a transfer occurs on any port when valid && ready in the same cycle. Once valid is asserted, data and last stay stable until the transfer.
- `load = !out_valid || out_ready`: the output register may be (re)filled this cycle.
- States (`merge_state_t`): `BOTH` (neither run finished), `ONLY_A` (B run finished), `ONLY_B` (A run finished).
- `BOTH`: act only when `a_valid && b_valid && load`.
  - Select A if `a_data <= b_data`, else B. Ties go to A, so the merge is stable.
  - Assert the selected ready and load its data into the output register.
  - If the selected element has `last`, move to `ONLY_B` (A selected) or `ONLY_A` (B selected).
  - Never pop on a single valid in `BOTH`.
- `ONLY_A`: pass A through when `a_valid && load`; `b_ready` = 0. On `a_last`, load with `out_last` = 1 and return to `BOTH`.
- `ONLY_B`: the mirror image of `ONLY_A`.
- `out_last` = 1 only on the element that ends both runs. The next pair of runs starts in `BOTH` on the following cycle with no bubble.
- Order check: per stream, hold the last accepted value and an `in_run` flag (cleared after a `last`). Accepting a value smaller than the held value while `in_run` is set sets `order_err`. Only `rst` clears `order_err`.
- Arithmetic: unsigned compare over the full WIDTH. No wrap or saturation; data passes unmodified.

## Timing
- Reset values: `out_valid` 0, `out_last` 0, `out_data` 0, `order_err` 0, state `BOTH`, `in_run` flags 0.
- While `rst` is high, `a_ready` = `b_ready` = 0.
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 element/cycle when `out_ready` is held high.
- `a_ready`/`b_ready` are combinational in `a_valid`, `b_valid`, data, state and `out_ready`. There is no combinational path to `out_*`.
- Backpressure: `out_ready` = 0 with `out_valid` = 1 holds `out_*` stable and deasserts both input readies.
- Simultaneous output drain and input pop in one cycle: the register takes the new element and `out_valid` stays 1.
- Reset mid-run: all in-flight state is dropped, the output register empties, and the block resumes in `BOTH`. Upstream must restart its runs.
- A single-element run (`valid` and `last` on the first beat) is legal.

## Structure
- Package `merge_pkg`: `merge_state_t` enum {`BOTH`, `ONLY_A`, `ONLY_B`} and `MERGE_WIDTH_DEFAULT` = 8.
- Sub-module `merge_select`: purely combinational. Takes both heads and the state, and produces `sel_a`, `sel_b` (one-hot or none) and `le` (a ≤ b). The top level holds the state register, output register and order checkers.

## Test plan
- A = {1,4,9}, B = {2,3,10}, `out_ready` = 1 → out {1,2,3,4,9,10}, `out_last` only on 10, one element per cycle after the first.
- Ties: A = {5,5}, B = {5} → out 5(A),5(A),5(B). Check the source order via tagged data at WIDTH = 9.
- Uneven runs: A = {7} (`last`), B = {1,2,8,20} → out {1,2,7,8,20}. State passes through `ONLY_B` after 7, and 20 carries `out_last`.
- Backpressure: toggle `out_ready` pseudo-randomly on the first scenario → same sequence, `out_*` stable while stalled, no drops or duplicates.
- Order error: A = {3,2}, B = {4} → `order_err` rises the cycle after 2 is accepted and stays high until `rst`. The merge still completes.
- Reset mid-run: assert `rst` after two outputs → the next cycle shows `out_valid` 0 and state `BOTH`. Fresh runs A = {0}, B = {255} then produce {0,255}.
